// File: rtl/msd_dimm_cmd_issuer.sv
// rtl/msd_dimm_cmd_issuer.sv - closed-page DDR5 command issuer
// Pops one request at a time and plays ACT0/ACT1/CAS0/CAS1/PRE with DIMM-clock spacing.
module msd_dimm_cmd_issuer #(
  parameter int T_RCD  = 39,
  parameter int T_RTP  = 18,
  parameter int T_WPRE = 118,
  parameter int T_RP   = 39
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req_valid,
  input  logic [1:0]  i_req_op,
  input  logic [35:0] i_req_addr,
  output logic        o_req_ready,
  output logic        o_cmd_valid,
  output logic [2:0]  o_cmd_code,
  output logic        o_cmd_ch,
  output logic [2:0]  o_cmd_bg,
  output logic [1:0]  o_cmd_ba,
  output logic [15:0] o_cmd_row,
  output logic [5:0]  o_cmd_col,
  output logic        o_busy,
  output logic        o_err_op
);

  if (T_RCD < 2 || T_RCD > 255) begin : g_bad_rcd
    $error("T_RCD must be in 2..255");
  end
  if (T_RTP < 2 || T_RTP > 255) begin : g_bad_rtp
    $error("T_RTP must be in 2..255");
  end
  if (T_WPRE < 2 || T_WPRE > 255) begin : g_bad_wpre
    $error("T_WPRE must be in 2..255");
  end
  if (T_RP < 2 || T_RP > 255) begin : g_bad_rp
    $error("T_RP must be in 2..255");
  end

  // Counter reads 0 in the reference command cycle, so a gap of T ends when it reaches T-1.
  localparam logic [7:0] L_RCD_M1  = 8'(T_RCD - 1);
  localparam logic [7:0] L_RTP_M1  = 8'(T_RTP - 1);
  localparam logic [7:0] L_WPRE_M1 = 8'(T_WPRE - 1);
  localparam logic [7:0] L_RP_M1   = 8'(T_RP - 1);

  localparam logic [2:0] C_ACT0 = 3'd0;
  localparam logic [2:0] C_ACT1 = 3'd1;
  localparam logic [2:0] C_RD0  = 3'd2;
  localparam logic [2:0] C_RD1  = 3'd3;
  localparam logic [2:0] C_WR0  = 3'd4;
  localparam logic [2:0] C_WR1  = 3'd5;
  localparam logic [2:0] C_PRE  = 3'd6;

  typedef enum logic [3:0] {
    S_IDLE, S_ACT0, S_ACT1, S_WRCD, S_CAS0, S_CAS1, S_WPRE, S_PRE, S_WRP
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [7:0]  r_cnt;
  logic        r_is_wr;
  logic        w_accept;
  logic        w_pop_cmd;
  logic        w_cmd_vld;
  logic [2:0]  w_cmd_code;
  logic [7:0]  w_cas_gap_m1;
  logic        w_unused_addr;

  assign w_accept      = i_req_valid & o_req_ready;
  assign w_pop_cmd     = w_accept & (i_req_op != 2'd3);
  assign w_cas_gap_m1  = r_is_wr ? L_WPRE_M1 : L_RTP_M1;
  assign w_unused_addr = ^{i_req_addr[35:34], i_req_addr[5:0]};

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (w_pop_cmd) w_next = S_ACT0;
      S_ACT0: w_next = S_ACT1;
      S_ACT1, S_WRCD: w_next = (r_cnt >= L_RCD_M1) ? S_CAS0 : S_WRCD;
      S_CAS0: w_next = S_CAS1;
      S_CAS1, S_WPRE: w_next = (r_cnt >= w_cas_gap_m1) ? S_PRE : S_WPRE;
      S_PRE:  w_next = S_WRP;
      S_WRP:  if (r_cnt >= L_RP_M1) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they register alongside it.
  always_comb begin
    w_cmd_vld  = 1'b1;
    w_cmd_code = C_ACT0;
    unique case (w_next)
      S_ACT0: w_cmd_code = C_ACT0;
      S_ACT1: w_cmd_code = C_ACT1;
      S_CAS0: w_cmd_code = r_is_wr ? C_WR0 : C_RD0;
      S_CAS1: w_cmd_code = r_is_wr ? C_WR1 : C_RD1;
      S_PRE:  w_cmd_code = C_PRE;
      default: w_cmd_vld = 1'b0;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= 8'd0;
      r_is_wr     <= 1'b0;
      o_req_ready <= 1'b1;
      o_cmd_valid <= 1'b0;
      o_cmd_code  <= 3'd0;
      o_cmd_ch    <= 1'b0;
      o_cmd_bg    <= 3'd0;
      o_cmd_ba    <= 2'd0;
      o_cmd_row   <= 16'd0;
      o_cmd_col   <= 6'd0;
      o_busy      <= 1'b0;
      o_err_op    <= 1'b0;
    end else begin
      r_state     <= w_next;
      o_req_ready <= (w_next == S_IDLE);
      o_busy      <= (w_next != S_IDLE);
      o_err_op    <= w_accept & (i_req_op == 2'd3);
      o_cmd_valid <= w_cmd_vld;
      if (w_cmd_vld) o_cmd_code <= w_cmd_code;
      if (w_next == S_ACT0 || w_next == S_CAS0 || w_next == S_PRE) r_cnt <= 8'd0;
      else if (r_cnt != 8'hFF) r_cnt <= r_cnt + 8'd1;
      if (w_pop_cmd) begin
        r_is_wr   <= (i_req_op == 2'd1);
        o_cmd_ch  <= i_req_addr[6];
        o_cmd_bg  <= i_req_addr[9:7];
        o_cmd_ba  <= i_req_addr[11:10];
        o_cmd_row <= i_req_addr[33:18];
        o_cmd_col <= i_req_addr[17:12];
      end
    end
  end

endmodule

// File: tb/tb_msd_dimm_cmd_issuer.sv
// tb/tb_msd_dimm_cmd_issuer.sv - scoreboard bench for msd_dimm_cmd_issuer
// Stimulus pushes expected events with absolute cycles; a negedge monitor pops and compares.
module tb_msd_dimm_cmd_issuer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic [1:0]  req_op = 2'd0;
  logic [35:0] req_addr = 36'd0;
  logic        req_ready, cmd_valid, cmd_ch, busy, err_op;
  logic [2:0]  cmd_code, cmd_bg;
  logic [1:0]  cmd_ba;
  logic [15:0] cmd_row;
  logic [5:0]  cmd_col;

  msd_dimm_cmd_issuer dut (
    .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid), .i_req_op(req_op),
    .i_req_addr(req_addr), .o_req_ready(req_ready), .o_cmd_valid(cmd_valid),
    .o_cmd_code(cmd_code), .o_cmd_ch(cmd_ch), .o_cmd_bg(cmd_bg), .o_cmd_ba(cmd_ba),
    .o_cmd_row(cmd_row), .o_cmd_col(cmd_col), .o_busy(busy), .o_err_op(err_op)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  localparam int K_CMD = 0;
  localparam int K_ERR = 1;
  localparam int K_RDY = 2;

  typedef struct {
    int          kind;
    int          at;
    logic [2:0]  code;
    logic        ch;
    logic [2:0]  bg;
    logic [1:0]  ba;
    logic [15:0] row;
    logic [5:0]  col;
  } evt_t;

  evt_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  logic prev_ready = 1'b1;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic observe(input int kind);
    evt_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event: got kind %0d code %0d expected none (cycle %0d)",
               kind, cmd_code, cyc);
      return;
    end
    checks--;
    e = exp_q.pop_front();
    chk("event_kind", kind, e.kind);
    chk("event_cycle", cyc, e.at);
    if (kind == K_CMD && e.kind == K_CMD) begin
      chk("cmd_code", cmd_code, e.code);
      chk("cmd_ch", cmd_ch, e.ch);
      chk("cmd_bg", cmd_bg, e.bg);
      chk("cmd_ba", cmd_ba, e.ba);
      chk("cmd_row", cmd_row, e.row);
      chk("cmd_col", cmd_col, e.col);
      chk("busy_on_cmd", busy, 1);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (cmd_valid) observe(K_CMD);
      if (err_op) observe(K_ERR);
      if (req_ready && !prev_ready) observe(K_RDY);
    end
    prev_ready = req_ready;
  end

  task automatic push(input int kind, input int at, input logic [2:0] code, input logic ch,
                      input logic [2:0] bg, input logic [1:0] ba, input logic [15:0] row,
                      input logic [5:0] col);
    evt_t e;
    e.kind = kind; e.at = at; e.code = code;
    e.ch = ch; e.bg = bg; e.ba = ba; e.row = row; e.col = col;
    exp_q.push_back(e);
  endtask

  // Presents a request, waits for the pop, then queues the hand-computed command schedule.
  task automatic issue(input logic [1:0] op, input logic [35:0] addr, input logic ch,
                       input logic [2:0] bg, input logic [1:0] ba, input logic [15:0] row,
                       input logic [5:0] col, input bit keep, output int acc);
    int n;
    @(negedge clk);
    req_op = op; req_addr = addr; req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) chk("accept_timeout", 0, 1);
    acc = cyc;
    if (op == 2'd3) begin
      push(K_ERR, acc + 1, 3'd0, 1'b0, 3'd0, 2'd0, 16'd0, 6'd0);
    end else begin
      push(K_CMD, acc + 1, 3'd0, ch, bg, ba, row, col);
      push(K_CMD, acc + 2, 3'd1, ch, bg, ba, row, col);
      push(K_CMD, acc + 40, (op == 2'd1) ? 3'd4 : 3'd2, ch, bg, ba, row, col);
      push(K_CMD, acc + 41, (op == 2'd1) ? 3'd5 : 3'd3, ch, bg, ba, row, col);
      push(K_CMD, acc + ((op == 2'd1) ? 158 : 58), 3'd6, ch, bg, ba, row, col);
      push(K_RDY, acc + ((op == 2'd1) ? 197 : 97), 3'd0, 1'b0, 3'd0, 2'd0, 16'd0, 6'd0);
    end
    @(posedge clk);
    #1;
    if (!keep) req_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 600) begin
      @(negedge clk);
      n++;
    end
    chk("drain_queue_left", exp_q.size(), 0);
  endtask

  localparam logic [35:0] A1 = 36'h0_0005_3C40;
  localparam logic [35:0] A2 = 36'h8_1234_5678;

  initial begin
    int a, b;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", req_ready, 1);
    chk("rst_cmd_valid", cmd_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err_op", err_op, 0);
    chk("rst_cmd_code", cmd_code, 0);
    chk("rst_cmd_row", cmd_row, 0);
    rst = 1'b0;

    issue(2'd0, A1, 1'b1, 3'd0, 2'd3, 16'd1, 6'd19, 1'b0, a);
    drain();
    issue(2'd1, A1, 1'b1, 3'd0, 2'd3, 16'd1, 6'd19, 1'b0, a);
    drain();
    issue(2'd2, A1, 1'b1, 3'd0, 2'd3, 16'd1, 6'd19, 1'b0, a);
    drain();

    issue(2'd3, A2, 1'b0, 3'd0, 2'd0, 16'd0, 6'd0, 1'b0, a);
    #1;
    chk("err_ready_hold1", req_ready, 1);
    repeat (6) begin
      @(negedge clk);
      chk("err_ready_stays", req_ready, 1);
      chk("err_no_busy", busy, 0);
    end
    drain();

    issue(2'd0, A1, 1'b1, 3'd0, 2'd3, 16'd1, 6'd19, 1'b1, a);
    issue(2'd0, A2, 1'b1, 3'd4, 2'd1, 16'h048D, 6'd5, 1'b0, b);
    chk("b2b_second_accept", b - a, 97);
    drain();

    issue(2'd0, A1, 1'b1, 3'd0, 2'd3, 16'd1, 6'd19, 1'b0, a);
    while (cyc < a + 45) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_cmd_valid", cmd_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_cmd_code", cmd_code, 0);
    chk("midrst_cmd_row", cmd_row, 0);
    chk("midrst_cmd_ba", cmd_ba, 0);
    chk("midrst_req_ready", req_ready, 1);
    chk("midrst_pending", exp_q.size(), 2);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("postrst_ready", req_ready, 1);
    issue(2'd0, A2, 1'b1, 3'd4, 2'd1, 16'h048D, 6'd5, 1'b0, a);
    drain();
    repeat (5) @(negedge clk);
    chk("final_queue_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
